// File: rtl/regfile_write_arbiter_if.sv
// Write-request bus shared by the two writeback sources and the regfile
// write port. The sources drive the master side; the arbiter is the slave.
interface regfile_write_arbiter_if #(
    parameter int DW = 64,
    parameter int AW = 5
);
    logic          req0_valid;
    logic          req0_ready;
    logic [AW-1:0] req0_reg;
    logic [DW-1:0] req0_data;

    logic          req1_valid;
    logic          req1_ready;
    logic [AW-1:0] req1_reg;
    logic [DW-1:0] req1_data;

    logic          regWrite;
    logic [AW-1:0] writeRegister;
    logic [DW-1:0] writeData;
    logic          idle;

    modport master (
        output req0_valid, req0_reg, req0_data,
        input  req0_ready,
        output req1_valid, req1_reg, req1_data,
        input  req1_ready,
        input  regWrite, writeRegister, writeData, idle
    );

    modport slave (
        input  req0_valid, req0_reg, req0_data,
        output req0_ready,
        input  req1_valid, req1_reg, req1_data,
        output req1_ready,
        output regWrite, writeRegister, writeData, idle
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the single regfile write port between the ALU writeback (source 0)
// and the load unit (source 1). Each source feeds a DEPTH-entry FIFO; a
// round-robin arbiter pops at most one head per cycle and registers the
// write controls. Writes aimed at X31 are popped but never reach the
// regfile because X31 is hardwired to zero. DEPTH must be a power of two
// and at least 2 so the pointers wrap naturally.
module regfile_write_arbiter #(
    parameter int DEPTH = 2,
    parameter int DW    = 64,
    parameter int AW    = 5
) (
    input logic                   clk,
    input logic                   reset,
    regfile_write_arbiter_if.slave bus
);
    localparam int            PW       = $clog2(DEPTH);
    localparam int            CW       = PW + 1;
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [AW-1:0] ZERO_REG = AW'(31);

    logic [AW-1:0] r_memReg  [2][DEPTH];
    logic [DW-1:0] r_memData [2][DEPTH];
    logic [PW-1:0] r_wrPtr   [2];
    logic [PW-1:0] r_rdPtr   [2];
    logic [CW-1:0] r_count   [2];
    logic          r_prio;
    logic          r_regWrite;
    logic [AW-1:0] r_writeRegister;
    logic [DW-1:0] r_writeData;

    logic [1:0]    w_valid;
    logic [1:0]    w_ready;
    logic [1:0]    w_notEmpty;
    logic [1:0]    w_push;
    logic [1:0]    w_grant;
    logic          w_anyGrant;
    logic [AW-1:0] w_inReg  [2];
    logic [DW-1:0] w_inData [2];
    logic [AW-1:0] w_headReg;
    logic [DW-1:0] w_headData;

    assign w_valid     = {bus.req1_valid, bus.req0_valid};
    assign w_inReg[0]  = bus.req0_reg;
    assign w_inReg[1]  = bus.req1_reg;
    assign w_inData[0] = bus.req0_data;
    assign w_inData[1] = bus.req1_data;

    // Ready and occupancy come only from the registered counts, so a full
    // FIFO never accepts even when it is being popped in the same cycle.
    always_comb begin
        w_ready    = '0;
        w_notEmpty = '0;
        for (int i = 0; i < 2; i++) begin
            w_ready[i]    = (r_count[i] < FULL);
            w_notEmpty[i] = (r_count[i] != '0);
        end
    end

    assign w_push = w_valid & w_ready;

    // Round-robin: a lone non-empty FIFO always wins, a tie goes to r_prio.
    assign w_grant[0] = w_notEmpty[0] & (~w_notEmpty[1] | ~r_prio);
    assign w_grant[1] = w_notEmpty[1] & (~w_notEmpty[0] |  r_prio);
    assign w_anyGrant = |w_grant;

    assign w_headReg  = w_grant[1] ? r_memReg[1][r_rdPtr[1]]  : r_memReg[0][r_rdPtr[0]];
    assign w_headData = w_grant[1] ? r_memData[1][r_rdPtr[1]] : r_memData[0][r_rdPtr[0]];

    // FIFO storage; contents are don't-care until the count says otherwise.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (w_push[i]) begin
                r_memReg[i][r_wrPtr[i]]  <= w_inReg[i];
                r_memData[i][r_wrPtr[i]] <= w_inData[i];
            end
        end
    end

    // FIFO pointers and counts; a pop and a push together leave the count alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                r_wrPtr[i] <= '0;
                r_rdPtr[i] <= '0;
                r_count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_push[i]) begin
                    r_wrPtr[i] <= r_wrPtr[i] + PW'(1);
                end
                if (w_grant[i]) begin
                    r_rdPtr[i] <= r_rdPtr[i] + PW'(1);
                end
                case ({w_push[i], w_grant[i]})
                    2'b10:   r_count[i] <= r_count[i] + CW'(1);
                    2'b01:   r_count[i] <= r_count[i] - CW'(1);
                    default: r_count[i] <= r_count[i];
                endcase
            end
        end
    end

    // Registered write port and fairness pointer; an X31 head still uses its grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prio          <= 1'b0;
            r_regWrite      <= 1'b0;
            r_writeRegister <= '0;
            r_writeData     <= '0;
        end else begin
            r_regWrite <= w_anyGrant && (w_headReg != ZERO_REG);
            if (w_anyGrant) begin
                r_writeRegister <= w_headReg;
                r_writeData     <= w_headData;
                r_prio          <= w_grant[0];
            end
        end
    end

    // Popping an empty FIFO or pushing a full one would corrupt the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                assert (!(w_grant[i] && !w_notEmpty[i]))
                    else $error("pop of empty FIFO %0d", i);
                assert (!(w_push[i] && !w_ready[i]))
                    else $error("push into full FIFO %0d", i);
                assert (r_count[i] <= FULL)
                    else $error("count overflow on FIFO %0d", i);
            end
        end
    end

    assign bus.req0_ready    = w_ready[0];
    assign bus.req1_ready    = w_ready[1];
    assign bus.regWrite      = r_regWrite;
    assign bus.writeRegister = r_writeRegister;
    assign bus.writeData     = r_writeData;
    assign bus.idle          = (r_count[0] == '0) && (r_count[1] == '0) && !r_regWrite;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: a queue-based model of the two FIFOs and
// round-robin arbiter predicts the write port every cycle; accepted writes
// are queued as expected results and matched against observed regfile writes.
module tb_regfile_write_arbiter;
    localparam int DEPTH = 2;
    localparam int DW    = 64;
    localparam int AW    = 5;

    typedef struct packed {
        logic [AW-1:0] rg;
        logic [DW-1:0] data;
    } entry_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.DW(DW), .AW(AW)) bus ();

    regfile_write_arbiter #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    entry_t        mq0[$];
    entry_t        mq1[$];
    entry_t        expWrites[$];
    entry_t        gotWrites[$];
    logic          mPrio;
    logic          mRegWrite;
    logic [AW-1:0] mWReg;
    logic [DW-1:0] mWData;
    logic [DW-1:0] tbRegfile [32];
    int            total = 0;
    int            bad   = 0;

    function automatic logic [AW+DW+3:0] expStatus();
        logic mIdle;
        mIdle = (mq0.size() == 0) && (mq1.size() == 0) && !mRegWrite;
        return {mRegWrite, mWReg, mWData, mIdle, mq0.size() < DEPTH, mq1.size() < DEPTH};
    endfunction

    function automatic logic [AW+DW+3:0] obsStatus();
        return {bus.regWrite, bus.writeRegister, bus.writeData, bus.idle,
                bus.req0_ready, bus.req1_ready};
    endfunction

    task automatic modelReset();
        mq0.delete();
        mq1.delete();
        expWrites.delete();
        gotWrites.delete();
        mPrio     = 1'b0;
        mRegWrite = 1'b0;
        mWReg     = '0;
        mWData    = '0;
    endtask

    task automatic idleInputs();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic doReset();
        idleInputs();
        reset = 1'b0;
        #1;
        modelReset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock: predict the edge from the model, apply it, record DUT writes.
    task automatic cycle();
        entry_t h;
        entry_t e;
        logic   p0, p1, g0, g1;
        p0 = bus.req0_valid && (mq0.size() < DEPTH);
        p1 = bus.req1_valid && (mq1.size() < DEPTH);
        g0 = (mq0.size() != 0) && ((mq1.size() == 0) || !mPrio);
        g1 = (mq1.size() != 0) && !g0;
        if (bus.regWrite) tbRegfile[bus.writeRegister] = bus.writeData;
        if (g0 || g1) begin
            if (g0) h = mq0.pop_front();
            else    h = mq1.pop_front();
            mRegWrite = (h.rg != AW'(31));
            mWReg     = h.rg;
            mWData    = h.data;
            mPrio     = g0;
            if (mRegWrite) expWrites.push_back(h);
        end else begin
            mRegWrite = 1'b0;
        end
        if (p0) begin
            e.rg = bus.req0_reg; e.data = bus.req0_data; mq0.push_back(e);
        end
        if (p1) begin
            e.rg = bus.req1_reg; e.data = bus.req1_data; mq1.push_back(e);
        end
        @(posedge clk);
        #1;
        if (bus.regWrite) begin
            e.rg = bus.writeRegister; e.data = bus.writeData; gotWrites.push_back(e);
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (obsStatus() !== {1'b0, AW'(0), DW'(0), 1'b1, 1'b1, 1'b1}) begin
            bad++;
            $display("[TB] FAIL reset_initial got=%h want=%h", obsStatus(),
                     {1'b0, AW'(0), DW'(0), 1'b1, 1'b1, 1'b1});
        end
        modelReset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            bus.req0_valid = 1'b1; bus.req0_reg = AW'(1); bus.req0_data = DW'(100 + i);
            bus.req1_valid = 1'b1; bus.req1_reg = AW'(2); bus.req1_data = DW'(200 + i);
            cycle();
            total++;
            if (obsStatus() !== expStatus()) begin
                bad++;
                $display("[TB] FAIL reset_stream got=%h want=%h", obsStatus(), expStatus());
            end
        end
        idleInputs();
        reset = 1'b0;
        #1;
        total++;
        if ({bus.regWrite, bus.req0_ready, bus.req1_ready, bus.idle} !== 4'b0111) begin
            bad++;
            $display("[TB] FAIL reset_async got=%b want=0111",
                     {bus.regWrite, bus.req0_ready, bus.req1_ready, bus.idle});
        end
        modelReset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++;
            if (obsStatus() !== expStatus()) begin
                bad++;
                $display("[TB] FAIL reset_after got=%h want=%h", obsStatus(), expStatus());
            end
        end
        total++;
        if (gotWrites.size() != 0) begin
            bad++;
            $display("[TB] FAIL reset_nowrite got=%0d writes want=0", gotWrites.size());
        end
    endtask

    task automatic test_single_write();
        bus.req0_valid = 1'b1; bus.req0_reg = AW'(5); bus.req0_data = 64'hDEAD_BEEF;
        cycle();
        idleInputs();
        cycle();
        total++;
        if ({bus.regWrite, bus.writeRegister, bus.writeData} !== {1'b1, AW'(5), 64'hDEAD_BEEF}) begin
            bad++;
            $display("[TB] FAIL single_write got=%h want=%h",
                     {bus.regWrite, bus.writeRegister, bus.writeData}, {1'b1, AW'(5), 64'hDEAD_BEEF});
        end
        cycle();
        total++;
        if ({bus.regWrite, bus.idle} !== 2'b01) begin
            bad++;
            $display("[TB] FAIL single_idle got=%b want=01", {bus.regWrite, bus.idle});
        end
    endtask

    task automatic test_back_to_back();
        logic seen0 = 1'b0;
        logic seen1 = 1'b0;
        int   guard = 0;
        doReset();
        for (int i = 0; i < 8; i++) begin
            bus.req0_valid = 1'b1; bus.req0_reg = AW'(8 + i);
            bus.req0_data  = 64'h0000_0000_0000_0300 + DW'(i);
            bus.req1_valid = 1'b1; bus.req1_reg = AW'(16 + i);
            bus.req1_data  = 64'h1000_0000_0000_0300 + DW'(i);
            cycle();
            if (!bus.req0_ready) seen0 = 1'b1;
            if (!bus.req1_ready) seen1 = 1'b1;
            total++;
            if (obsStatus() !== expStatus()) begin
                bad++;
                $display("[TB] FAIL b2b_status got=%h want=%h", obsStatus(), expStatus());
            end
        end
        idleInputs();
        while ((mq0.size() != 0 || mq1.size() != 0 || mRegWrite) && guard < 30) begin
            cycle();
            guard++;
            total++;
            if (obsStatus() !== expStatus()) begin
                bad++;
                $display("[TB] FAIL b2b_drain got=%h want=%h", obsStatus(), expStatus());
            end
        end
        total++;
        if ({seen0, seen1} !== 2'b11) begin
            bad++;
            $display("[TB] FAIL b2b_ready_drop got=%b want=11", {seen0, seen1});
        end
        total++;
        if (gotWrites.size() < 8) begin
            bad++;
            $display("[TB] FAIL b2b_count got=%0d want>=8", gotWrites.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (gotWrites[i].data[60] !== 1'(i % 2)) begin
                    bad++;
                    $display("[TB] FAIL b2b_alternate write%0d got=%0d want=%0d",
                             i, gotWrites[i].data[60], i % 2);
                end
            end
        end
        total++;
        if (gotWrites.size() != expWrites.size()) begin
            bad++;
            $display("[TB] FAIL b2b_total got=%0d want=%0d", gotWrites.size(), expWrites.size());
        end
        while (expWrites.size() != 0 && gotWrites.size() != 0) begin
            entry_t g, x;
            g = gotWrites.pop_front();
            x = expWrites.pop_front();
            total++;
            if (g !== x) begin
                bad++;
                $display("[TB] FAIL b2b_write got=%h want=%h", g, x);
            end
        end
    endtask

    task automatic test_discard_x31();
        gotWrites.delete();
        expWrites.delete();
        bus.req1_valid = 1'b1; bus.req1_reg = AW'(31); bus.req1_data = 64'h3131;
        cycle();
        bus.req1_reg = AW'(3); bus.req1_data = 64'h0303;
        cycle();
        total++;
        if (bus.regWrite !== 1'b0) begin
            bad++;
            $display("[TB] FAIL x31_discard got=%b want=0", bus.regWrite);
        end
        idleInputs();
        cycle();
        total++;
        if ({bus.regWrite, bus.writeRegister, bus.writeData} !== {1'b1, AW'(3), 64'h0303}) begin
            bad++;
            $display("[TB] FAIL x31_next got=%h want=%h",
                     {bus.regWrite, bus.writeRegister, bus.writeData}, {1'b1, AW'(3), 64'h0303});
        end
        cycle();
        total++;
        if (gotWrites.size() != 1) begin
            bad++;
            $display("[TB] FAIL x31_count got=%0d want=1", gotWrites.size());
        end
    endtask

    task automatic test_hold_when_full();
        int     sent0 = 0;
        int     sent1 = 0;
        int     guard = 0;
        logic   acc0, acc1;
        entry_t g;
        int     n0 = 0;
        gotWrites.delete();
        expWrites.delete();
        while ((sent0 < 3 || sent1 < 6) && guard < 50) begin
            bus.req0_valid = (sent0 < 3); bus.req0_reg = AW'(10 + sent0);
            bus.req0_data  = 64'h500 + DW'(sent0);
            bus.req1_valid = (sent1 < 6); bus.req1_reg = AW'(20 + sent1);
            bus.req1_data  = 64'h1000_0000_0000_0000 + DW'(sent1);
            acc0 = bus.req0_valid && (mq0.size() < DEPTH);
            acc1 = bus.req1_valid && (mq1.size() < DEPTH);
            cycle();
            if (acc0) sent0++;
            if (acc1) sent1++;
            guard++;
            total++;
            if (obsStatus() !== expStatus()) begin
                bad++;
                $display("[TB] FAIL hold_status got=%h want=%h", obsStatus(), expStatus());
            end
        end
        idleInputs();
        guard = 0;
        while ((mq0.size() != 0 || mq1.size() != 0 || mRegWrite) && guard < 30) begin
            cycle();
            guard++;
            total++;
            if (obsStatus() !== expStatus()) begin
                bad++;
                $display("[TB] FAIL hold_drain got=%h want=%h", obsStatus(), expStatus());
            end
        end
        for (int i = 0; i < gotWrites.size(); i++) begin
            g = gotWrites[i];
            if (g.data[60] == 1'b0) begin
                total++;
                if (g.data !== 64'h500 + DW'(n0)) begin
                    bad++;
                    $display("[TB] FAIL hold_order got=%h want=%h", g.data, 64'h500 + DW'(n0));
                end
                n0++;
            end
        end
        total++;
        if (n0 != 3) begin
            bad++;
            $display("[TB] FAIL hold_count got=%0d want=3", n0);
        end
    endtask

    task automatic test_same_register();
        doReset();
        tbRegfile[7] = '0;
        bus.req0_valid = 1'b1; bus.req0_reg = AW'(7); bus.req0_data = 64'h1;
        bus.req1_valid = 1'b1; bus.req1_reg = AW'(7); bus.req1_data = 64'h2;
        cycle();
        idleInputs();
        for (int i = 0; i < 4; i++) begin
            cycle();
            total++;
            if (obsStatus() !== expStatus()) begin
                bad++;
                $display("[TB] FAIL same_status got=%h want=%h", obsStatus(), expStatus());
            end
        end
        total++;
        if (gotWrites.size() != 2) begin
            bad++;
            $display("[TB] FAIL same_count got=%0d want=2", gotWrites.size());
        end else begin
            total++;
            if ({gotWrites[0].data, gotWrites[1].data} !== {64'h1, 64'h2}) begin
                bad++;
                $display("[TB] FAIL same_order got=%h,%h want=1,2",
                         gotWrites[0].data, gotWrites[1].data);
            end
        end
        total++;
        if (tbRegfile[7] !== 64'h2) begin
            bad++;
            $display("[TB] FAIL same_final got=%h want=2", tbRegfile[7]);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) tbRegfile[i] = '0;
        reset          = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_reg = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_reg = '0; bus.req1_data = '0;
        test_reset();
        test_single_write();
        test_back_to_back();
        test_discard_x31();
        test_hold_when_full();
        test_same_register();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
